// File: rtl/core_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// core_pkg : TOY opcode/state types and instruction decode helpers. Rev 1.0
// ---------------------------------------------------------------------------
package core_pkg;

    typedef enum logic [3:0] {
        OP_HALT = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
        OP_XOR  = 4'h4, OP_SHL = 4'h5, OP_SHR = 4'h6, OP_LDA = 4'h7,
        OP_LD   = 4'h8, OP_ST  = 4'h9, OP_LDI = 4'hA, OP_STI = 4'hB,
        OP_BZ   = 4'hC, OP_BP  = 4'hD, OP_JR  = 4'hE, OP_JAL = 4'hF
    } opcode_t;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    localparam int REG_AW = 4;

    function automatic opcode_t instr_op(input logic [15:0] instr);
        return opcode_t'(instr[15:12]);
    endfunction

    function automatic logic [3:0] instr_rd(input logic [15:0] instr);
        return instr[11:8];
    endfunction

    function automatic logic [3:0] instr_rs(input logic [15:0] instr);
        return instr[7:4];
    endfunction

    function automatic logic [3:0] instr_rt(input logic [15:0] instr);
        return instr[3:0];
    endfunction

    function automatic logic [7:0] instr_imm(input logic [15:0] instr);
        return instr[7:0];
    endfunction

    function automatic logic is_alu(input opcode_t op);
        return (op >= OP_ADD) && (op <= OP_SHR);
    endfunction

    // Stores and branches read d through port 0 instead of s.
    function automatic logic uses_port0(input opcode_t op);
        return is_alu(op) || (op == OP_ST) || (op == OP_STI) ||
               (op == OP_BZ) || (op == OP_BP) || (op == OP_JR);
    endfunction

    function automatic logic uses_port1(input opcode_t op);
        return is_alu(op) || (op == OP_LDI) || (op == OP_STI);
    endfunction

    function automatic logic writes_rd(input opcode_t op);
        return is_alu(op) || (op == OP_LDA) || (op == OP_LD) ||
               (op == OP_LDI) || (op == OP_JAL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------------------
// core_scoreboard : pending-write busy bits with set/clear and lookups. Rev 1.0
// ---------------------------------------------------------------------------
module core_scoreboard #(
    parameter int NUM_WB = 2
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic                set_en_i,
    input  logic [3:0]          set_addr_i,
    input  logic [NUM_WB-1:0]   clr_en_i,
    input  logic [4*NUM_WB-1:0] clr_addr_i,
    input  logic [3:0]          chk0_addr_i,
    input  logic [3:0]          chk1_addr_i,
    output logic                chk0_busy_o,
    output logic                chk1_busy_o,
    output logic [15:0]         busy_o
);

    logic [15:0] busy_q;
    logic [15:0] busy_d;

    // Set is applied after the clears so a same-edge set/clear leaves it busy.
    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < NUM_WB; k++) begin
            if (clr_en_i[k]) begin
                busy_d[clr_addr_i[k*4 +: 4]] = 1'b0;
            end
        end
        if (set_en_i) begin
            busy_d[set_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign chk0_busy_o = busy_q[chk0_addr_i];
    assign chk1_busy_o = busy_q[chk1_addr_i];
    assign busy_o      = busy_q;

endmodule
`default_nettype wire

// File: rtl/core_id.sv
`default_nettype none
// ---------------------------------------------------------------------------
// core_id : TOY decode/operand-read stage with scoreboard, HALT and flush. Rev 1.0
// ---------------------------------------------------------------------------
module core_id
    import core_pkg::*;
#(
    parameter int NUM_WB = 2
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic                if_valid_i,
    output logic                if_ready_o,
    input  logic [15:0]         if_instr_i,
    input  logic [7:0]          if_pc_i,
    input  logic                flush_i,
    input  logic                resume_i,
    output logic [3:0]          arf_raddr0_o,
    input  logic [15:0]         arf_rdata0_i,
    output logic [3:0]          arf_raddr1_o,
    input  logic [15:0]         arf_rdata1_i,
    output logic                ex_valid_o,
    input  logic                ex_ready_i,
    output logic [3:0]          ex_op_o,
    output logic [3:0]          ex_rd_o,
    output logic                ex_wen_o,
    output logic [15:0]         ex_a_o,
    output logic [15:0]         ex_b_o,
    output logic [7:0]          ex_imm_o,
    output logic [7:0]          ex_pc_o,
    input  logic [NUM_WB-1:0]   wb_en_i,
    input  logic [4*NUM_WB-1:0] wb_addr_i,
    output logic                halted_o
);

    state_t      state_q, state_d;
    logic        slot_valid_q, slot_valid_d;
    logic [15:0] slot_instr_q, slot_instr_d;
    logic [7:0]  slot_pc_q, slot_pc_d;

    opcode_t     op;
    logic [3:0]  rd;
    logic        running;
    logic        src0_busy, src1_busy;
    logic [15:0] busy;
    logic        hazard;
    logic        issue;
    logic        accept;
    logic        halt_go;

    assign op      = instr_op(slot_instr_q);
    assign rd      = instr_rd(slot_instr_q);
    assign running = (state_q == ST_RUN);

    // Unused ports read R0, which is never busy, so the hazard needs no use mask.
    assign arf_raddr0_o = is_alu(op)     ? instr_rs(slot_instr_q) :
                          uses_port0(op) ? rd : 4'd0;
    assign arf_raddr1_o = uses_port1(op) ? instr_rt(slot_instr_q) : 4'd0;

    assign ex_wen_o = writes_rd(op) && (rd != 4'd0);
    assign hazard   = src0_busy || src1_busy || (ex_wen_o && busy[rd]);

    assign ex_valid_o = slot_valid_q && running && !hazard && (op != OP_HALT) && !flush_i;
    assign issue      = ex_valid_o && ex_ready_i;
    assign if_ready_o = running && !flush_i && (!slot_valid_q || issue);
    assign accept     = if_valid_i && if_ready_o;
    assign halt_go    = slot_valid_q && running && (op == OP_HALT) && !flush_i;

    assign ex_op_o  = op;
    assign ex_rd_o  = rd;
    assign ex_a_o   = arf_rdata0_i;
    assign ex_b_o   = arf_rdata1_i;
    assign ex_imm_o = instr_imm(slot_instr_q);
    assign ex_pc_o  = slot_pc_q;
    assign halted_o = (state_q == ST_HALTED);

    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_instr_d = slot_instr_q;
        slot_pc_d    = slot_pc_q;
        state_d      = state_q;
        if (flush_i) begin
            slot_valid_d = 1'b0;
        end else if (accept) begin
            slot_valid_d = 1'b1;
            slot_instr_d = if_instr_i;
            slot_pc_d    = if_pc_i;
        end else if (issue || halt_go) begin
            slot_valid_d = 1'b0;
        end
        case (state_q)
            ST_RUN:    if (halt_go) state_d = ST_HALTED;
            ST_HALTED: if (resume_i || flush_i) state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q      <= ST_RUN;
            slot_valid_q <= 1'b0;
            slot_instr_q <= '0;
            slot_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            slot_valid_q <= slot_valid_d;
            slot_instr_q <= slot_instr_d;
            slot_pc_q    <= slot_pc_d;
        end
    end

    core_scoreboard #(
        .NUM_WB(NUM_WB)
    ) u_sb (
        .clk_i      (clk_i),
        .arst_i     (arst_i),
        .set_en_i   (issue && ex_wen_o),
        .set_addr_i (rd),
        .clr_en_i   (wb_en_i),
        .clr_addr_i (wb_addr_i),
        .chk0_addr_i(arf_raddr0_o),
        .chk1_addr_i(arf_raddr1_o),
        .chk0_busy_o(src0_busy),
        .chk1_busy_o(src1_busy),
        .busy_o     (busy)
    );

endmodule
`default_nettype wire

// File: tb/tb_core_id.sv
`default_nettype none
// tb_core_id : directed and random stimulus for core_id against a
// transaction-level model of the slot, scoreboard, ARF and HALT state.
module tb_core_id;

    logic        clk_i = 1'b0;
    logic        arst_i;
    logic        if_valid_i;
    logic        if_ready_o;
    logic [15:0] if_instr_i;
    logic [7:0]  if_pc_i;
    logic        flush_i;
    logic        resume_i;
    logic [3:0]  arf_raddr0_o;
    logic [15:0] arf_rdata0_i;
    logic [3:0]  arf_raddr1_o;
    logic [15:0] arf_rdata1_i;
    logic        ex_valid_o;
    logic        ex_ready_i;
    logic [3:0]  ex_op_o;
    logic [3:0]  ex_rd_o;
    logic        ex_wen_o;
    logic [15:0] ex_a_o;
    logic [15:0] ex_b_o;
    logic [7:0]  ex_imm_o;
    logic [7:0]  ex_pc_o;
    logic [1:0]  wb_en_i;
    logic [7:0]  wb_addr_i;
    logic        halted_o;

    logic [15:0] arf [16];
    logic [15:0] wb_data [2];

    bit          m_slot_v;
    bit          m_halted;
    logic [15:0] m_instr;
    logic [7:0]  m_pc;
    logic [15:0] m_busy;
    int          pend[$];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_i = ~clk_i;

    assign arf_rdata0_i = arf[arf_raddr0_o];
    assign arf_rdata1_i = arf[arf_raddr1_o];

    core_id #(.NUM_WB(2)) u_dut (
        .clk_i(clk_i), .arst_i(arst_i),
        .if_valid_i(if_valid_i), .if_ready_o(if_ready_o),
        .if_instr_i(if_instr_i), .if_pc_i(if_pc_i),
        .flush_i(flush_i), .resume_i(resume_i),
        .arf_raddr0_o(arf_raddr0_o), .arf_rdata0_i(arf_rdata0_i),
        .arf_raddr1_o(arf_raddr1_o), .arf_rdata1_i(arf_rdata1_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .ex_op_o(ex_op_o), .ex_rd_o(ex_rd_o), .ex_wen_o(ex_wen_o),
        .ex_a_o(ex_a_o), .ex_b_o(ex_b_o), .ex_imm_o(ex_imm_o), .ex_pc_o(ex_pc_o),
        .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .halted_o(halted_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic bit in_pend(input logic [3:0] a);
        foreach (pend[i]) if (pend[i] == int'(a)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic pend_remove(input logic [3:0] a);
        int idx[$];
        idx = pend.find_first_index(x) with (x == int'(a));
        if (idx.size() != 0) pend.delete(idx[0]);
    endtask

    task automatic idle();
        if_valid_i = 1'b0; flush_i = 1'b0; resume_i = 1'b0; ex_ready_i = 1'b1;
        wb_en_i = '0; wb_addr_i = '0;
    endtask

    task automatic present(input logic [15:0] instr, input logic [7:0] pc);
        if_valid_i = 1'b1; if_instr_i = instr; if_pc_i = pc;
    endtask

    // Called just after a falling edge with inputs driven: checks the cycle's
    // outputs, then advances the model across the rising edge.
    task automatic cycle();
        logic [3:0] op, d, a0, a1;
        bit u0, u1, wr, stall, ev, iss, ifr, acc, hgo;
        #1;
        op = m_instr[15:12];
        d  = m_instr[11:8];
        u0 = (op inside {[4'h1:4'h6], 4'h9, [4'hB:4'hE]});
        a0 = (op inside {[4'h1:4'h6]}) ? m_instr[7:4] : (u0 ? d : 4'h0);
        u1 = (op inside {[4'h1:4'h6], 4'hA, 4'hB});
        a1 = u1 ? m_instr[3:0] : 4'h0;
        wr = (op inside {[4'h1:4'h8], 4'hA, 4'hF}) && (d != 4'h0);
        stall = (u0 && m_busy[a0]) || (u1 && m_busy[a1]) || (wr && m_busy[d]);
        ev  = m_slot_v && !m_halted && !stall && (op != 4'h0) && !flush_i;
        iss = ev && ex_ready_i;
        ifr = !m_halted && !flush_i && (!m_slot_v || iss);
        check_eq("ex_valid", ex_valid_o, ev);
        check_eq("if_ready", if_ready_o, ifr);
        check_eq("halted", halted_o, m_halted);
        check_eq("raddr0", arf_raddr0_o, a0);
        check_eq("raddr1", arf_raddr1_o, a1);
        check_eq("busy", u_dut.u_sb.busy_o, m_busy);
        if (ev) begin
            check_eq("ex_op", ex_op_o, op);
            check_eq("ex_rd", ex_rd_o, d);
            check_eq("ex_wen", ex_wen_o, wr);
            check_eq("ex_a", ex_a_o, arf[a0]);
            check_eq("ex_b", ex_b_o, arf[a1]);
            check_eq("ex_imm", ex_imm_o, m_instr[7:0]);
            check_eq("ex_pc", ex_pc_o, m_pc);
        end
        acc = if_valid_i && ifr;
        hgo = m_slot_v && !m_halted && (op == 4'h0) && !flush_i;
        @(posedge clk_i);
        for (int k = 0; k < 2; k++) begin
            if (wb_en_i[k]) begin
                m_busy[wb_addr_i[k*4 +: 4]] = 1'b0;
                arf[wb_addr_i[k*4 +: 4]]    = wb_data[k];
                pend_remove(wb_addr_i[k*4 +: 4]);
            end
        end
        if (iss && wr) begin
            m_busy[d] = 1'b1;
            pend.push_back(int'(d));
        end
        if (flush_i) m_slot_v = 1'b0;
        else if (acc) begin
            m_slot_v = 1'b1; m_instr = if_instr_i; m_pc = if_pc_i;
        end else if (iss || hgo) m_slot_v = 1'b0;
        if (!m_halted && hgo) m_halted = 1'b1;
        else if (m_halted && (resume_i || flush_i)) m_halted = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic drain();
        int guard = 0;
        if_valid_i = 1'b0; flush_i = 1'b0; resume_i = 1'b0; ex_ready_i = 1'b1;
        while (pend.size() != 0 && guard < 64) begin
            wb_en_i = '0; wb_addr_i = '0;
            wb_en_i[0] = 1'b1; wb_addr_i[3:0] = 4'(pend[0]); wb_data[0] = 16'($urandom);
            if (pend.size() > 1) begin
                wb_en_i[1] = 1'b1; wb_addr_i[7:4] = 4'(pend[1]); wb_data[1] = 16'($urandom);
            end
            cycle();
            guard++;
        end
        check_eq("drain_done", 32'(pend.size()), 32'd0);
        wb_en_i = '0; wb_addr_i = '0;
    endtask

    task automatic drive_wb_random();
        wb_en_i = '0; wb_addr_i = '0;
        for (int k = 0; k < 2; k++) begin
            int r;
            logic [3:0] a;
            bit take;
            r = int'($urandom_range(0, 9));
            take = 1'b0;
            a = 4'h0;
            if (r < 4 && pend.size() > 0) begin
                a = 4'(pend[$urandom_range(0, pend.size() - 1)]);
                take = 1'b1;
            end else if (r == 9) begin
                a = 4'($urandom_range(1, 15));
                take = !in_pend(a);
            end
            if (k == 1 && wb_en_i[0] && wb_addr_i[3:0] == a) take = 1'b0;
            if (take) begin
                wb_en_i[k] = 1'b1; wb_addr_i[k*4 +: 4] = a; wb_data[k] = 16'($urandom);
            end
        end
    endtask

    task automatic drive_random();
        logic [3:0] op;
        op = 4'($urandom_range(0, 15));
        if (op == 4'h0 && $urandom_range(0, 3) != 0) op = 4'h1;
        if_valid_i = ($urandom_range(0, 9) < 7);
        if_instr_i = {op, 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))};
        if_pc_i    = 8'($urandom);
        ex_ready_i = ($urandom_range(0, 9) < 7);
        flush_i    = ($urandom_range(0, 19) == 0);
        resume_i   = ($urandom_range(0, 2) == 0);
        drive_wb_random();
    endtask

    initial begin
        arf[0] = 16'h0;
        for (int i = 1; i < 16; i++) arf[i] = 16'($urandom);
        wb_data[0] = '0; wb_data[1] = '0;
        // Reset with garbage inputs
        arst_i = 1'b1;
        if_valid_i = 1'b1; if_instr_i = 16'($urandom); if_pc_i = 8'($urandom);
        flush_i = 1'b0; resume_i = 1'b1; ex_ready_i = 1'b1;
        wb_en_i = 2'b11; wb_addr_i = 8'($urandom);
        #12;
        check_eq("rst_ex_valid", ex_valid_o, 1'b0);
        check_eq("rst_halted", halted_o, 1'b0);
        check_eq("rst_if_ready", if_ready_o, 1'b1);
        check_eq("rst_busy", u_dut.u_sb.busy_o, 16'h0);
        m_slot_v = 1'b0; m_halted = 1'b0; m_instr = '0; m_pc = '0; m_busy = '0;
        @(negedge clk_i);
        arst_i = 1'b0;
        idle();

        // RAW stall on R3, released by a writeback of 0x00AB
        present(16'h1312, 8'h10); cycle();
        present(16'h2434, 8'h11); cycle();
        if_valid_i = 1'b0;
        #1 check_eq("raw_stall", ex_valid_o, 1'b0);
        cycle(); cycle();
        wb_en_i = 2'b01; wb_addr_i = 8'h03; wb_data[0] = 16'h00AB; cycle();
        wb_en_i = 2'b00;
        #1 check_eq("raw_release", ex_valid_o, 1'b1);
        check_eq("raw_a", ex_a_o, 16'h00AB);
        cycle();

        // R0 destination is not tracked
        present(16'h7005, 8'h20); cycle();
        present(16'h1100, 8'h21);
        #1 check_eq("r0_wen", ex_wen_o, 1'b0);
        cycle();
        if_valid_i = 1'b0;
        #1 check_eq("r0_nostall", ex_valid_o, 1'b1);
        cycle();
        drain();

        // HALT then resume; HALT then flush
        present(16'h0000, 8'h30); cycle();
        if_valid_i = 1'b0;
        #1 check_eq("halt_noissue", ex_valid_o, 1'b0);
        cycle();
        #1 check_eq("halt_state", halted_o, 1'b1);
        check_eq("halt_ready", if_ready_o, 1'b0);
        resume_i = 1'b1; cycle(); resume_i = 1'b0;
        #1 check_eq("resume_state", halted_o, 1'b0);
        check_eq("resume_ready", if_ready_o, 1'b1);
        present(16'h0000, 8'h31); cycle();
        if_valid_i = 1'b0; cycle();
        flush_i = 1'b1; cycle(); flush_i = 1'b0;
        #1 check_eq("flush_exit", halted_o, 1'b0);
        check_eq("flush_exit_ready", if_ready_o, 1'b1);

        // Flush colliding with a pending issue and a fetch
        ex_ready_i = 1'b0; present(16'h1567, 8'h40); cycle();
        ex_ready_i = 1'b1; present(16'h1888, 8'h41); flush_i = 1'b1;
        #1 check_eq("flush_noissue", ex_valid_o, 1'b0);
        check_eq("flush_noaccept", if_ready_o, 1'b0);
        cycle();
        flush_i = 1'b0; if_valid_i = 1'b0;
        #1 check_eq("flush_empty", ex_valid_o, 1'b0);
        check_eq("flush_busy7", u_dut.u_sb.busy_o[7], 1'b0);
        cycle();

        // Backpressure then back-to-back issue
        present(16'h1123, 8'h50); cycle();
        ex_ready_i = 1'b0; present(16'h2A9B, 8'h51);
        #1 check_eq("bp_if_ready", if_ready_o, 1'b0);
        for (int i = 0; i < 3; i++) cycle();
        check_eq("bp_busy1", u_dut.u_sb.busy_o[1], 1'b0);
        ex_ready_i = 1'b1; cycle();
        if_valid_i = 1'b0;
        #1 check_eq("b2b_valid", ex_valid_o, 1'b1);
        check_eq("b2b_busy1", u_dut.u_sb.busy_o[1], 1'b1);
        cycle();
        drain();

        // Same-edge set and clear of R9
        present(16'h1900, 8'h60); cycle();
        if_valid_i = 1'b0; wb_en_i = 2'b10; wb_addr_i = 8'h90; wb_data[1] = 16'h1234;
        cycle();
        wb_en_i = 2'b00;
        #1 check_eq("set_wins", u_dut.u_sb.busy_o[9], 1'b1);
        cycle();
        drain();

        for (int i = 0; i < 3000; i++) begin
            drive_random();
            cycle();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
